cop_irq_timer: RTL and testbench

- Memory-mapped responder on the core's coprocessor port (cop_addr/cop_data/cop_mem_ctl in, cop_dout out) and the source of the core's irq/irq_addr/iack handshake.
- Contains a prescaled 32-bit timer with compare and optional auto-reload, an edge-detected external interrupt line, pending and mask registers, and a programmable interrupt vector.
- Read data returns one cycle after the access, aligned with the core's write-back stage.

---
 rtl/cop_irq_timer.sv | 212 +++++++++++++++++++++
 tb/tb_cop_irq_timer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_irq_timer.sv
// ---------------------------------------------------------------------------
// cop_irq_timer
//   Memory-mapped timer / interrupt controller on the core's coprocessor port.
//   It holds a prescaled 32-bit timer with compare and optional auto-reload,
//   an edge-detected external interrupt line, and pending and mask registers.
//   It drives the core's irq / irq_addr / iack handshake.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   cop_addr_i      access address (MEM stage)
//   cop_data_i      store data (MEM stage)
//   cop_mem_ctl_i   access type: LW_CODE = load, SW_CODE = store, else idle
//   cop_dout_o      registered read data; 0 whenever no load hit last cycle
//   ext_irq_i       external interrupt request, rising-edge sensitive
//   iack_i          one-cycle interrupt acknowledge from the core
//   irq_o           registered interrupt request to the core
//   irq_addr_o      handler address (the VECTOR register)
//
// Register map (offset = addr[4:2], addr[1:0] ignored)
//   0 CTRL     bit0 TEN, bit1 GIE, bit2 AUTO
//   1 COUNT    timer value
//   2 CMP      compare value
//   3 STATUS   bit0 TPEND, bit1 XPEND, bit2 BUSY (W1C pendings, write clears BUSY)
//   4 MASK     bits[1:0] enable TPEND / XPEND
//   5 VECTOR   handler address
//   6 PRESCALE bits[15:0]
//   7          reads 0, writes ignored
// ---------------------------------------------------------------------------
module cop_irq_timer #(
  parameter logic [31:0] BASE    = 32'hFFFF_FF00,
  parameter logic [3:0]  LW_CODE = 4'b0001,
  parameter logic [3:0]  SW_CODE = 4'b0010,
  parameter logic [31:0] VEC_RST = 32'h0000_0050
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cop_addr_i,
  input  logic [31:0] cop_data_i,
  input  logic [3:0]  cop_mem_ctl_i,
  output logic [31:0] cop_dout_o,
  input  logic        ext_irq_i,
  input  logic        iack_i,
  output logic        irq_o,
  output logic [31:0] irq_addr_o
);

  // Architectural state
  logic [2:0]  ctrl;       // {AUTO, GIE, TEN}
  logic [31:0] count;
  logic [31:0] cmp;
  logic        tpend;
  logic        xpend;
  logic        busy;
  logic [1:0]  mask;
  logic [31:0] vector;
  logic [15:0] prescale;
  logic [15:0] pre_cnt;
  logic        ext_q;
  logic        irq_q;
  logic [31:0] dout_q;

  // Next-state values
  logic [2:0]  ctrl_n;
  logic [31:0] count_n;
  logic [31:0] cmp_n;
  logic        tpend_n;
  logic        xpend_n;
  logic        busy_n;
  logic [1:0]  mask_n;
  logic [31:0] vector_n;
  logic [15:0] prescale_n;
  logic [15:0] pre_cnt_n;
  logic        irq_n;
  logic [31:0] dout_n;

  // Decode. The XOR/mask form compares addr[31:5] against BASE[31:5].
  logic        hit;
  logic        ld_hit;
  logic        st_hit;
  logic [2:0]  off;
  logic [31:0] rdata;

  assign hit    = ((cop_addr_i ^ BASE) & 32'hFFFF_FFE0) == 32'h0;
  assign ld_hit = hit && (cop_mem_ctl_i == LW_CODE);
  assign st_hit = hit && (cop_mem_ctl_i == SW_CODE);
  assign off    = cop_addr_i[4:2];

  logic wr_ctrl, wr_count, wr_cmp, wr_status, wr_mask, wr_vector, wr_prescale;
  assign wr_ctrl     = st_hit && (off == 3'd0);
  assign wr_count    = st_hit && (off == 3'd1);
  assign wr_cmp      = st_hit && (off == 3'd2);
  assign wr_status   = st_hit && (off == 3'd3);
  assign wr_mask     = st_hit && (off == 3'd4);
  assign wr_vector   = st_hit && (off == 3'd5);
  assign wr_prescale = st_hit && (off == 3'd6);

  // Timer / pending logic
  logic tick;
  logic match;
  logic ext_rise;
  logic iack_ok;

  assign ext_rise = ext_irq_i & ~ext_q;

  // Interrupt handshake: irq_o is a registered level. The core answers with a
  // single-cycle iack_i while irq_o is high; that sets BUSY, which masks
  // irq_o from the next cycle on. Software rearms by writing STATUS, which
  // clears BUSY. An iack_i seen while irq_o is low is not a handshake and is
  // ignored.
  assign iack_ok = iack_i & irq_q;

  always_comb begin
    tick      = 1'b0;
    match     = 1'b0;
    pre_cnt_n = pre_cnt;
    count_n   = count;

    if (ctrl[0]) begin
      if (pre_cnt == prescale) begin
        pre_cnt_n = 16'h0;
        tick      = 1'b1;
      end else begin
        pre_cnt_n = pre_cnt + 16'd1;
      end
    end

    // A software COUNT write overrides the tick and suppresses the compare.
    if (wr_count) begin
      count_n = cop_data_i;
    end else if (tick) begin
      if (count == cmp) begin
        match   = 1'b1;
        count_n = ctrl[2] ? 32'h0 : count + 32'd1;
      end else begin
        count_n = count + 32'd1;
      end
    end
  end

  always_comb begin
    ctrl_n     = wr_ctrl     ? cop_data_i[2:0]  : ctrl;
    cmp_n      = wr_cmp      ? cop_data_i       : cmp;
    mask_n     = wr_mask     ? cop_data_i[1:0]  : mask;
    vector_n   = wr_vector   ? cop_data_i       : vector;
    prescale_n = wr_prescale ? cop_data_i[15:0] : prescale;

    // Hardware set takes priority over a same-cycle write-1-to-clear.
    tpend_n = match    | (tpend & ~(wr_status & cop_data_i[0]));
    xpend_n = ext_rise | (xpend & ~(wr_status & cop_data_i[1]));

    // Acknowledge beats a same-cycle STATUS write.
    if (iack_ok)        busy_n = 1'b1;
    else if (wr_status) busy_n = 1'b0;
    else                busy_n = busy;

    irq_n = ctrl_n[1] & ~busy_n & |({xpend_n, tpend_n} & mask_n);
  end

  // Read mux sees register values before any same-cycle update.
  always_comb begin
    rdata = 32'h0;
    case (off)
      3'd0: rdata = {29'h0, ctrl};
      3'd1: rdata = count;
      3'd2: rdata = cmp;
      3'd3: rdata = {29'h0, busy, xpend, tpend};
      3'd4: rdata = {30'h0, mask};
      3'd5: rdata = vector;
      3'd6: rdata = {16'h0, prescale};
      default: rdata = 32'h0;
    endcase
    // Zero when idle: the core ORs this into its write-back data.
    dout_n = ld_hit ? rdata : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= 3'h0;
      count    <= 32'h0;
      cmp      <= 32'hFFFF_FFFF;
      tpend    <= 1'b0;
      xpend    <= 1'b0;
      busy     <= 1'b0;
      mask     <= 2'h0;
      vector   <= VEC_RST;
      prescale <= 16'h0;
      pre_cnt  <= 16'h0;
      ext_q    <= 1'b0;
      irq_q    <= 1'b0;
      dout_q   <= 32'h0;
    end else begin
      ctrl     <= ctrl_n;
      count    <= count_n;
      cmp      <= cmp_n;
      tpend    <= tpend_n;
      xpend    <= xpend_n;
      busy     <= busy_n;
      mask     <= mask_n;
      vector   <= vector_n;
      prescale <= prescale_n;
      pre_cnt  <= pre_cnt_n;
      ext_q    <= ext_irq_i;
      irq_q    <= irq_n;
      dout_q   <= dout_n;
    end
  end

  assign cop_dout_o = dout_q;
  assign irq_o      = irq_q;
  assign irq_addr_o = vector;

endmodule

// File: tb/tb_cop_irq_timer.sv
// ---------------------------------------------------------------------------
// tb_cop_irq_timer
//   Directed, self-checking bench for cop_irq_timer. Register loads are
//   applied from small vector tables; timer, interrupt and reset corner cases
//   are hand-written sequences with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cop_irq_timer;

  localparam logic [31:0] BASE    = 32'hFFFF_FF00;
  localparam logic [3:0]  LW      = 4'b0001;
  localparam logic [3:0]  SW      = 4'b0010;
  localparam logic [3:0]  IDLE    = 4'b0000;
  localparam int          W       = 32;

  // ---- clock / reset ----
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cop_addr_i = 32'h0;
  logic [31:0] cop_data_i = 32'h0;
  logic [3:0]  cop_mem_ctl_i = 4'h0;
  logic [31:0] cop_dout_o;
  logic        ext_irq_i = 1'b0;
  logic        iack_i = 1'b0;
  logic        irq_o;
  logic [31:0] irq_addr_o;

  always #5 clk = ~clk;

  cop_irq_timer dut (
    .clk           (clk),
    .rst           (rst),
    .cop_addr_i    (cop_addr_i),
    .cop_data_i    (cop_data_i),
    .cop_mem_ctl_i (cop_mem_ctl_i),
    .cop_dout_o    (cop_dout_o),
    .ext_irq_i     (ext_irq_i),
    .iack_i        (iack_i),
    .irq_o         (irq_o),
    .irq_addr_o    (irq_addr_o)
  );

  // ---- scoreboard ----
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---- driver tasks ----
  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    cop_addr_i    = BASE + {27'h0, off, 2'b00};
    cop_data_i    = data;
    cop_mem_ctl_i = SW;
    cyc();
    cop_mem_ctl_i = IDLE;
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string name);
    cop_addr_i    = BASE + {27'h0, off, 2'b00};
    cop_mem_ctl_i = LW;
    exp_q.push_back(exp);
    cyc();
    cop_mem_ctl_i = IDLE;
    chk(name, cop_dout_o, exp_q.pop_front());
  endtask

  // ---- vector tables ----
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t rst_tab[10];
  vec_t miss_tab[8];

  task automatic run_vec(input vec_t v);
    cop_mem_ctl_i = v.ctl;
    cop_addr_i    = v.addr;
    cop_data_i    = v.data;
    exp_q.push_back(v.exp);
    cyc();
    cop_mem_ctl_i = IDLE;
    chk(v.name, cop_dout_o, exp_q.pop_front());
  endtask

  task automatic run_rst_tab();
    for (int i = 0; i < 10; i++) run_vec(rst_tab[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset register values, one load per offset, byte lanes ignored on one.
    rst_tab[0] = '{LW,   32'hFFFF_FF00, 32'h0, 32'h0000_0000, "rst_ctrl"};
    rst_tab[1] = '{LW,   32'hFFFF_FF04, 32'h0, 32'h0000_0000, "rst_count"};
    rst_tab[2] = '{LW,   32'hFFFF_FF0B, 32'h0, 32'hFFFF_FFFF, "rst_cmp"};
    rst_tab[3] = '{LW,   32'hFFFF_FF0C, 32'h0, 32'h0000_0000, "rst_status"};
    rst_tab[4] = '{LW,   32'hFFFF_FF10, 32'h0, 32'h0000_0000, "rst_mask"};
    rst_tab[5] = '{LW,   32'hFFFF_FF14, 32'h0, 32'h0000_0050, "rst_vector"};
    rst_tab[6] = '{LW,   32'hFFFF_FF18, 32'h0, 32'h0000_0000, "rst_prescale"};
    rst_tab[7] = '{LW,   32'hFFFF_FF1C, 32'h0, 32'h0000_0000, "rst_off7"};
    rst_tab[8] = '{IDLE, 32'hFFFF_FF14, 32'h0, 32'h0000_0000, "idle_zero0"};
    rst_tab[9] = '{IDLE, 32'hFFFF_FF14, 32'h0, 32'h0000_0000, "idle_zero1"};

    // Misses and non-access codes must not change state or return data.
    miss_tab[0] = '{SW,    32'hFFFF_FF54, 32'hDEAD_BEEF, 32'h0,         "miss_st_vec"};
    miss_tab[1] = '{SW,    32'hFFFF_FF44, 32'h0000_1234, 32'h0,         "miss_st_cnt"};
    miss_tab[2] = '{LW,    32'hFFFF_FF54, 32'h0,         32'h0,         "miss_ld_vec"};
    miss_tab[3] = '{4'h4,  32'hFFFF_FF14, 32'hCAFE_F00D, 32'h0,         "noacc_st"};
    miss_tab[4] = '{4'h3,  32'hFFFF_FF14, 32'h0,         32'h0,         "noacc_ld"};
    miss_tab[5] = '{SW,    32'hFFFF_FF1C, 32'h1111_1111, 32'h0,         "st_off7"};
    miss_tab[6] = '{LW,    32'hFFFF_FF14, 32'h0,         32'h0000_0050, "after_miss_vec"};
    miss_tab[7] = '{LW,    32'hFFFF_FF04, 32'h0,         32'h0000_0000, "after_miss_cnt"};

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_irq_addr", irq_addr_o, 32'h0000_0050);
    rst = 1'b0;
    cyc();

    run_rst_tab();
    for (int i = 0; i < 8; i++) run_vec(miss_tab[i]);

    // ---- timer match with auto-reload ----
    wr(3'd2, 32'd5);
    wr(3'd4, 32'd1);
    wr(3'd6, 32'd0);
    wr(3'd0, 32'd7);           // ticks start on the next edge
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk($sformatf("pre_match_irq%0d", i), {31'h0, irq_o}, 32'h0);
    end
    cyc();                     // 6th tick: COUNT==CMP
    chk("match_irq", {31'h0, irq_o}, 32'h1);
    chk("match_irq_addr", irq_addr_o, 32'h0000_0050);
    rd(3'd1, 32'd0, "count_wrap");
    chk("irq_hold", {31'h0, irq_o}, 32'h1);

    // ---- acknowledge ----
    iack_i = 1'b1;
    cyc();
    iack_i = 1'b0;
    chk("iack_drop", {31'h0, irq_o}, 32'h0);
    rd(3'd3, 32'd5, "status_busy_tpend");
    wr(3'd3, 32'd1);
    chk("rearm_irq0", {31'h0, irq_o}, 32'h0);
    cyc();
    chk("rearm_irq1", {31'h0, irq_o}, 32'h0);
    cyc();                     // next auto-reload match
    chk("next_match_irq", {31'h0, irq_o}, 32'h1);
    wr(3'd0, 32'd0);
    wr(3'd3, 32'd1);
    chk("stopped_irq", {31'h0, irq_o}, 32'h0);

    // ---- prescaler: one COUNT step every 4 cycles ----
    wr(3'd1, 32'd0);
    wr(3'd6, 32'd3);
    wr(3'd0, 32'd1);
    repeat (39) cyc();
    wr(3'd0, 32'd0);           // 40th enabled edge, then frozen
    rd(3'd1, 32'd10, "prescale_count");
    repeat (8) cyc();
    rd(3'd1, 32'd10, "frozen_count");
    rd(3'd3, 32'd1, "match_no_auto");   // COUNT passed CMP=5 without reload
    cyc();
    chk("dout_idle", cop_dout_o, 32'h0);

    // ---- COUNT write on a tick wins and suppresses the compare ----
    wr(3'd3, 32'd1);
    wr(3'd6, 32'd0);
    wr(3'd2, 32'd7);
    wr(3'd1, 32'd7);
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd100);
    wr(3'd0, 32'd0);
    rd(3'd1, 32'd101, "count_wr_wins");
    rd(3'd3, 32'd0, "no_match_on_wr");

    // ---- external interrupt ----
    wr(3'd4, 32'd2);
    wr(3'd0, 32'd2);
    ext_irq_i = 1'b1;
    cyc();
    chk("ext_rise_irq", {31'h0, irq_o}, 32'h1);
    repeat (9) cyc();
    chk("ext_level_irq", {31'h0, irq_o}, 32'h1);
    rd(3'd3, 32'd2, "xpend_set");
    wr(3'd3, 32'd2);
    chk("xpend_clr_irq", {31'h0, irq_o}, 32'h0);
    rd(3'd3, 32'd0, "level_no_set");
    ext_irq_i = 1'b0;
    cyc();
    ext_irq_i = 1'b1;
    cyc();
    chk("ext_rise2_irq", {31'h0, irq_o}, 32'h1);
    rd(3'd3, 32'd2, "xpend_set2");

    // Set and W1C of XPEND in one cycle: set wins.
    ext_irq_i = 1'b0;
    cyc();
    ext_irq_i = 1'b1;
    wr(3'd3, 32'd2);
    rd(3'd3, 32'd2, "set_beats_clr");

    // iack while irq_o is low is ignored.
    wr(3'd0, 32'd0);
    chk("gie_off_irq", {31'h0, irq_o}, 32'h0);
    iack_i = 1'b1;
    cyc();
    iack_i = 1'b0;
    rd(3'd3, 32'd2, "iack_ignored");

    // iack and STATUS write together: iack wins.
    wr(3'd0, 32'd2);
    chk("gie_on_irq", {31'h0, irq_o}, 32'h1);
    iack_i = 1'b1;
    wr(3'd3, 32'd0);
    iack_i = 1'b0;
    chk("iack_vs_wr_irq", {31'h0, irq_o}, 32'h0);
    rd(3'd3, 32'd6, "iack_beats_wr");

    // ---- asynchronous reset mid-operation ----
    wr(3'd5, 32'h1234_5678);
    chk("vector_out", irq_addr_o, 32'h1234_5678);
    wr(3'd4, 32'd3);
    wr(3'd0, 32'd7);
    wr(3'd3, 32'd0);
    chk("pre_reset_irq", {31'h0, irq_o}, 32'h1);
    rd(3'd0, 32'd7, "pre_reset_ctrl");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_irq", {31'h0, irq_o}, 32'h0);
    chk("async_rst_vec", irq_addr_o, 32'h0000_0050);
    ext_irq_i = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    run_rst_tab();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
